// File: rtl/binary_search_ctrl_if.sv
// rtl/binary_search_ctrl_if.sv - controller/datapath bundle for binary_search_ctrl (Steps present with BSC_STEP_COUNT_EN)
interface binary_search_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              Start;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] q;
    logic [ADDR_W-1:0] LSB;
    logic [ADDR_W-1:0] MSB;
    logic [ADDR_W-1:0] M;
    logic              init;
    logic              compute_M;
    logic              Set_LSB;
    logic              Set_MSB;
    logic              Found;
    logic              Done;
`ifdef BSC_STEP_COUNT_EN
    logic [2:0]        Steps;

    modport master (
        input  Start, A, q, LSB, MSB, M,
        output init, compute_M, Set_LSB, Set_MSB, Found, Done, Steps
    );
    modport slave (
        output Start, A, q, LSB, MSB, M,
        input  init, compute_M, Set_LSB, Set_MSB, Found, Done, Steps
    );
`else
    modport master (
        input  Start, A, q, LSB, MSB, M,
        output init, compute_M, Set_LSB, Set_MSB, Found, Done
    );
    modport slave (
        output Start, A, q, LSB, MSB, M,
        input  init, compute_M, Set_LSB, Set_MSB, Found, Done
    );
`endif
endinterface

// File: rtl/binary_search_ctrl.sv
// rtl/binary_search_ctrl.sv - binary search FSM driving an external bounds/RAM datapath
// Optional CMP step counter output Steps enabled by BSC_STEP_COUNT_EN.
module binary_search_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic                 CLOCK_50,
    input  logic                 Reset,
    binary_search_ctrl_if.master bsc
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CMP,
        CALC,
        DONE
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(RD_LAT);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic              found_q, found_d;
    logic              done_q, done_d;
    logic              init_s, compute_m_s, set_lsb_s, set_msb_s;
    logic [ADDR_W-1:0] m_cur, lsb_cur, msb_cur;

    assign m_cur   = bsc.M;
    assign lsb_cur = bsc.LSB;
    assign msb_cur = bsc.MSB;

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            key_q      <= '0;
            wait_cnt_q <= '0;
            found_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            wait_cnt_q <= wait_cnt_d;
            found_q    <= found_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        wait_cnt_d  = wait_cnt_q;
        found_d     = found_q;
        done_d      = done_q;
        init_s      = 1'b0;
        compute_m_s = 1'b0;
        set_lsb_s   = 1'b0;
        set_msb_s   = 1'b0;
        case (state_q)
            IDLE: begin
                init_s     = 1'b1;
                wait_cnt_d = '0;
                found_d    = 1'b0;
                done_d     = 1'b0;
                if (bsc.Start) begin
                    key_d   = bsc.A;
                    state_d = WAIT;
                end
            end
            // First WAIT cycle is the address-update cycle, then RD_LAT read-latency cycles.
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = '0;
                    state_d    = CMP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            CMP: begin
                if (bsc.q == key_q) begin
                    state_d = DONE;
                    found_d = 1'b1;
                    done_d  = 1'b1;
                end else if (bsc.q < key_q) begin
                    // M at the upper bound: M+1 would wrap or leave the range.
                    if (m_cur == msb_cur) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        set_lsb_s = 1'b1;
                        state_d   = CALC;
                    end
                end else begin
                    if (m_cur == lsb_cur) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        set_msb_s = 1'b1;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                compute_m_s = 1'b1;
                state_d     = WAIT;
            end
            DONE: begin
                if (!bsc.Start) begin
                    state_d = IDLE;
                    found_d = 1'b0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bsc.init      = init_s;
    assign bsc.compute_M = compute_m_s;
    assign bsc.Set_LSB   = set_lsb_s;
    assign bsc.Set_MSB   = set_msb_s;
    assign bsc.Found     = found_q;
    assign bsc.Done      = done_q;

`ifdef BSC_STEP_COUNT_EN
    logic [2:0] steps_q, steps_d;

    always_comb begin
        steps_d = steps_q;
        if (state_q == IDLE) begin
            steps_d = '0;
        end else if (state_q == CMP) begin
            steps_d = steps_q + 3'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            steps_q <= '0;
        end else begin
            steps_q <= steps_d;
        end
    end

    assign bsc.Steps = steps_q;
`else
    // Step counter not built.
`endif
endmodule

// File: tb/tb_binary_search_ctrl.sv
// tb/tb_binary_search_ctrl.sv - binary_search_ctrl with bounds datapath and RAM[i]=2*i
module tb_binary_search_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 32;

    logic CLOCK_50 = 1'b0;
    logic Reset    = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    binary_search_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bsc ();

    binary_search_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .bsc      (bsc)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Datapath: bound registers, midpoint, and a one-cycle registered RAM holding 2*i.
    always @(posedge CLOCK_50) begin
        if (bsc.init) begin
            bsc.LSB <= '0;
            bsc.MSB <= 5'd31;
            bsc.M   <= 5'd15;
        end else if (bsc.Set_LSB) begin
            bsc.LSB <= bsc.M + 5'd1;
        end else if (bsc.Set_MSB) begin
            bsc.MSB <= bsc.M - 5'd1;
        end else if (bsc.compute_M) begin
            bsc.M <= 5'((6'(bsc.LSB) + 6'(bsc.MSB)) >> 1);
        end
        bsc.q <= DATA_W'({bsc.M, 1'b0});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Plain binary search over the table with the same termination rules at the bounds.
    task automatic ref_search(input int key, output int found, output int m,
                              output int steps, output int nlsb, output int nmsb);
        int lo, hi, mid;
        lo = 0; hi = DEPTH - 1; found = 0; steps = 0; nlsb = 0; nmsb = 0; mid = 0;
        forever begin
            mid = (lo + hi) / 2;
            steps++;
            if (2 * mid == key) begin
                found = 1;
                break;
            end else if (2 * mid < key) begin
                if (mid == hi) break;
                lo = mid + 1;
                nlsb++;
            end else begin
                if (mid == lo) break;
                hi = mid - 1;
                nmsb++;
            end
        end
        m = mid;
    endtask

    task automatic run_search(input int key, input bit hold);
        int e_found, e_m, e_steps, e_lsb, e_msb;
        int edges, nl, nm, multi, held_bad;
        ref_search(key, e_found, e_m, e_steps, e_lsb, e_msb);
        edges = 0; nl = 0; nm = 0; multi = 0; held_bad = 0;
        @(negedge CLOCK_50);
        bsc.A     = DATA_W'(key);
        bsc.Start = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        bsc.A = DATA_W'($urandom);
        if (!hold) bsc.Start = 1'b0;
        do begin
            @(posedge CLOCK_50);
            edges++;
            @(negedge CLOCK_50);
            if (!bsc.Done) begin
                nl += int'(bsc.Set_LSB);
                nm += int'(bsc.Set_MSB);
                if (int'(bsc.Set_LSB) + int'(bsc.Set_MSB) + int'(bsc.compute_M) + int'(bsc.init) > 1)
                    multi++;
            end
        end while (!bsc.Done && edges < 200);
        chk($sformatf("latency key=%0d", key), edges, 4 * e_steps - 1);
        chk($sformatf("done key=%0d", key), bsc.Done, 1);
        chk($sformatf("found key=%0d", key), bsc.Found, e_found);
        chk($sformatf("m key=%0d", key), bsc.M, e_m);
        chk($sformatf("set_lsb_cnt key=%0d", key), nl, e_lsb);
        chk($sformatf("set_msb_cnt key=%0d", key), nm, e_msb);
        chk($sformatf("one_strobe key=%0d", key), multi, 0);
        chk($sformatf("done_quiet key=%0d", key),
            {bsc.init, bsc.compute_M, bsc.Set_LSB, bsc.Set_MSB}, 0);
`ifdef BSC_STEP_COUNT_EN
        chk($sformatf("steps key=%0d", key), bsc.Steps, e_steps);
`endif
        if (hold) begin
            repeat (4) begin
                @(negedge CLOCK_50);
                if (bsc.Done !== 1'b1 || bsc.Found !== 1'(e_found) || bsc.M !== 5'(e_m)) held_bad++;
            end
            chk($sformatf("hold_stable key=%0d", key), held_bad, 0);
            bsc.Start = 1'b0;
        end
        @(negedge CLOCK_50);
        chk($sformatf("idle_done key=%0d", key), bsc.Done, 0);
        chk($sformatf("idle_found key=%0d", key), bsc.Found, 0);
        chk($sformatf("idle_init key=%0d", key), bsc.init, 1);
    endtask

    initial begin
        int n_calc;
        bsc.Start = 1'b0;
        bsc.A     = '0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_init", bsc.init, 1);
        chk("rst_strobes", {bsc.compute_M, bsc.Set_LSB, bsc.Set_MSB}, 0);
        chk("rst_done", bsc.Done, 0);
        chk("rst_found", bsc.Found, 0);
`ifdef BSC_STEP_COUNT_EN
        chk("rst_steps", bsc.Steps, 0);
`endif
        Reset = 1'b1;
        @(negedge CLOCK_50);

        run_search(30, 1'b0);
        run_search(0, 1'b0);
        run_search(61, 1'b0);
        run_search(62, 1'b1);

        // Reset asserted in the middle of the second CALC of a key=0 search.
        @(negedge CLOCK_50);
        bsc.A     = 8'd0;
        bsc.Start = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        bsc.Start = 1'b0;
        n_calc = 0;
        for (int i = 0; i < 100 && n_calc < 2; i++) begin
            @(negedge CLOCK_50);
            if (bsc.compute_M) n_calc++;
        end
        chk("mid_calc_seen", n_calc, 2);
        #1 Reset = 1'b0;
        #1;
        chk("mid_rst_init", bsc.init, 1);
        chk("mid_rst_done", bsc.Done, 0);
        chk("mid_rst_found", bsc.Found, 0);
        chk("mid_rst_calc", bsc.compute_M, 0);
        @(negedge CLOCK_50);
        Reset = 1'b1;
        run_search(30, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_search(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
